// File: rtl/mac_result_acc.sv
// mac_result_acc
//
// Sums a frame of unsigned terms from an upstream multiply-add stage and
// hands the frame sum, term count and an overflow flag to a downstream
// stage over a valid/ready handshake.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - upstream term valid
//   in_ready   - block accepts a term this cycle (low while a result is held)
//   in_data    - unsigned term, 2*DataWidth+1 bits
//   in_last    - final term of the frame, sampled only on an accepted term
//   out_valid  - frame result valid
//   out_ready  - downstream accepts the result
//   out_data   - frame sum, AccWidth bits
//   out_count  - number of terms summed, CountWidth bits
//   out_ovf    - frame sum exceeded 2^AccWidth-1
//
// Build option:
//   MAC_RESULT_ACC_SAT_EN - when defined, the accumulator clamps to all-ones
//   on overflow and stays there for the rest of the frame; otherwise it wraps.
//   out_ovf behaves the same either way.

module mac_result_acc #(
  parameter int DataWidth  = 32,
  parameter int CountWidth = 8,
  parameter int AccWidth   = 2*DataWidth+4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DataWidth:0]  in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AccWidth-1:0]   out_data,
  output logic [CountWidth-1:0] out_count,
  output logic                  out_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_live;
  logic [AccWidth-1:0]   r_acc;
  logic [CountWidth-1:0] r_cnt;
  logic                  r_ovf;
  logic [AccWidth-1:0]   r_outData;
  logic [CountWidth-1:0] r_outCount;
  logic                  r_outOvf;

  logic                  w_accept;
  logic [AccWidth:0]     w_sum;
  logic                  w_carry;
  logic [CountWidth-1:0] w_cntInc;
  logic [CountWidth-1:0] w_maxCnt;
  logic [AccWidth-1:0]   w_nextAcc;
  logic [CountWidth-1:0] w_nextCnt;
  logic                  w_nextOvf;
  logic                  w_load;

  // r_live holds in_ready low until the first clock edge after reset release.
  assign in_ready  = r_live && (r_state != OUT);
  assign out_valid = (r_state == OUT);
  assign out_data  = r_outData;
  assign out_count = r_outCount;
  assign out_ovf   = r_outOvf;

  assign w_accept = in_valid && in_ready;
  // One extra bit so the carry out of the accumulator is visible.
  assign w_sum    = {1'b0, r_acc} + (AccWidth+1)'(in_data);
  assign w_carry  = w_sum[AccWidth];
  assign w_cntInc = r_cnt + 1'b1;
  assign w_maxCnt = '1;

  // Next-state and next-accumulator logic. w_load marks the accepted term
  // that closes the frame, so the result registers capture the final values.
  always_comb begin
    w_nextState = r_state;
    w_nextAcc   = r_acc;
    w_nextCnt   = r_cnt;
    w_nextOvf   = r_ovf;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextAcc   = AccWidth'(in_data);
          w_nextCnt   = CountWidth'(1);
          w_nextOvf   = 1'b0;
          w_load      = in_last;
          w_nextState = in_last ? OUT : ACC;
        end
      end
      ACC: begin
        if (w_accept) begin
          w_nextOvf = r_ovf | w_carry;
`ifdef MAC_RESULT_ACC_SAT_EN
          // Once saturated the accumulator stays pinned for the frame.
          w_nextAcc = (r_ovf | w_carry) ? '1 : w_sum[AccWidth-1:0];
`else
          w_nextAcc = w_sum[AccWidth-1:0];
`endif
          w_nextCnt = w_cntInc;
          // A full counter ends the frame even without in_last.
          if (in_last || (w_cntInc == w_maxCnt)) begin
            w_load      = 1'b1;
            w_nextState = OUT;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State, accumulator and result registers; reset discards any partial
  // frame or undelivered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_live     <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_outData  <= '0;
      r_outCount <= '0;
      r_outOvf   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_live  <= 1'b1;
      r_acc   <= w_nextAcc;
      r_cnt   <= w_nextCnt;
      r_ovf   <= w_nextOvf;
      if (w_load) begin
        r_outData  <= w_nextAcc;
        r_outCount <= w_nextCnt;
        r_outOvf   <= w_nextOvf;
      end
    end
  end

endmodule

// File: tb/tb_mac_result_acc.sv
// Directed bench for mac_result_acc. Three instances cover the default
// configuration, a 2-bit term counter (forced frame end) and a narrow
// accumulator (overflow). Expected values are hand-computed constants.

module tb_mac_result_acc;

  logic clk = 1'b0;
  logic rst_n;

  // Instance A: default parameters
  logic        aInValid, aInReady, aInLast, aOutValid, aOutReady, aOutOvf;
  logic [64:0] aInData;
  logic [67:0] aOutData;
  logic [7:0]  aOutCount;

  // Instance B: CountWidth = 2
  logic        bInValid, bInReady, bInLast, bOutValid, bOutReady, bOutOvf;
  logic [64:0] bInData;
  logic [67:0] bOutData;
  logic [1:0]  bOutCount;

  // Instance C: DataWidth = 4, AccWidth = 12
  logic        cInValid, cInReady, cInLast, cOutValid, cOutReady, cOutOvf;
  logic [8:0]  cInData;
  logic [11:0] cOutData;
  logic [7:0]  cOutCount;

  int checks = 0;
  int errors = 0;

`ifdef MAC_RESULT_ACC_SAT_EN
  localparam logic [127:0] OvfSum = 128'd4095;
`else
  localparam logic [127:0] OvfSum = 128'd503;
`endif

  always #5 clk = ~clk;

  mac_result_acc dutA (
    .clk(clk), .rst_n(rst_n),
    .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData), .in_last(aInLast),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
    .out_count(aOutCount), .out_ovf(aOutOvf)
  );

  mac_result_acc #(.CountWidth(2)) dutB (
    .clk(clk), .rst_n(rst_n),
    .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData), .in_last(bInLast),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
    .out_count(bOutCount), .out_ovf(bOutOvf)
  );

  mac_result_acc #(.DataWidth(4), .AccWidth(12)) dutC (
    .clk(clk), .rst_n(rst_n),
    .in_valid(cInValid), .in_ready(cInReady), .in_data(cInData), .in_last(cInLast),
    .out_valid(cOutValid), .out_ready(cOutReady), .out_data(cOutData),
    .out_count(cOutCount), .out_ovf(cOutOvf)
  );

  // One comparison: counts it and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    aInValid = 1'b0; aInData = '0; aInLast = 1'b0; aOutReady = 1'b1;
    bInValid = 1'b0; bInData = '0; bInLast = 1'b0; bOutReady = 1'b1;
    cInValid = 1'b0; cInData = '0; cInLast = 1'b0; cOutReady = 1'b1;

    // Asynchronous reset, checked before any clock edge
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_a_in_ready",  128'(aInReady),  128'd0);
    checkOutput("rst_a_out_valid", 128'(aOutValid), 128'd0);
    checkOutput("rst_a_out_data",  128'(aOutData),  128'd0);
    checkOutput("rst_a_out_count", 128'(aOutCount), 128'd0);
    checkOutput("rst_a_out_ovf",   128'(aOutOvf),   128'd0);
    checkOutput("rst_b_out_valid", 128'(bOutValid), 128'd0);
    checkOutput("rst_c_in_ready",  128'(cInReady),  128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_a_in_ready_before_edge", 128'(aInReady), 128'd0);
    @(negedge clk);
    checkOutput("rel_a_in_ready_after_edge", 128'(aInReady), 128'd1);

    // A: three-term frame 10, 20, 30
    aInValid = 1'b1; aInData = 65'd10; aInLast = 1'b0;
    @(negedge clk);
    aInData = 65'd20;
    @(negedge clk);
    aInData = 65'd30; aInLast = 1'b1;
    @(negedge clk);
    checkOutput("f3_out_valid", 128'(aOutValid), 128'd1);
    checkOutput("f3_out_data",  128'(aOutData),  128'd60);
    checkOutput("f3_out_count", 128'(aOutCount), 128'd3);
    checkOutput("f3_out_ovf",   128'(aOutOvf),   128'd0);
    checkOutput("f3_in_ready",  128'(aInReady),  128'd0);
    aInValid = 1'b0; aInLast = 1'b0;
    @(negedge clk);
    checkOutput("f3_out_valid_fall", 128'(aOutValid), 128'd0);
    checkOutput("f3_out_data_held",  128'(aOutData),  128'd60);
    checkOutput("f3_in_ready_back",  128'(aInReady),  128'd1);

    // A: single-term frame 7, then held under backpressure
    aOutReady = 1'b0;
    aInValid = 1'b1; aInData = 65'd7; aInLast = 1'b1;
    @(negedge clk);
    checkOutput("f1_out_valid", 128'(aOutValid), 128'd1);
    checkOutput("f1_out_data",  128'(aOutData),  128'd7);
    checkOutput("f1_out_count", 128'(aOutCount), 128'd1);
    checkOutput("f1_in_ready",  128'(aInReady),  128'd0);
    aInData = 65'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 128'(aOutValid), 128'd1);
      checkOutput("bp_out_data",  128'(aOutData),  128'd7);
      checkOutput("bp_out_count", 128'(aOutCount), 128'd1);
      checkOutput("bp_in_ready",  128'(aInReady),  128'd0);
    end
    aOutReady = 1'b1; aInValid = 1'b0; aInLast = 1'b0;
    @(negedge clk);
    checkOutput("bp_release_out_valid", 128'(aOutValid), 128'd0);
    checkOutput("bp_release_in_ready",  128'(aInReady),  128'd1);
    checkOutput("bp_release_out_data",  128'(aOutData),  128'd7);

    // B: forced frame end with a 2-bit counter, terms 1 2 3 4, no in_last
    bInValid = 1'b1; bInData = 65'd1; bInLast = 1'b0;
    @(negedge clk);
    bInData = 65'd2;
    @(negedge clk);
    bInData = 65'd3;
    @(negedge clk);
    checkOutput("force_out_valid", 128'(bOutValid), 128'd1);
    checkOutput("force_out_data",  128'(bOutData),  128'd6);
    checkOutput("force_out_count", 128'(bOutCount), 128'd3);
    checkOutput("force_in_ready",  128'(bInReady),  128'd0);
    bInData = 65'd4;
    @(negedge clk);
    checkOutput("force_gap_out_valid", 128'(bOutValid), 128'd0);
    checkOutput("force_gap_in_ready",  128'(bInReady),  128'd1);
    bInLast = 1'b1;
    @(negedge clk);
    checkOutput("force_next_out_valid", 128'(bOutValid), 128'd1);
    checkOutput("force_next_out_data",  128'(bOutData),  128'd4);
    checkOutput("force_next_out_count", 128'(bOutCount), 128'd1);
    bInValid = 1'b0; bInLast = 1'b0;

    // C: nine terms of 511 overflow a 12-bit accumulator (4599)
    cInValid = 1'b1; cInData = 9'd511; cInLast = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
    end
    cInLast = 1'b1;
    @(negedge clk);
    checkOutput("ovf_out_valid", 128'(cOutValid), 128'd1);
    checkOutput("ovf_out_ovf",   128'(cOutOvf),   128'd1);
    checkOutput("ovf_out_data",  128'(cOutData),  OvfSum);
    checkOutput("ovf_out_count", 128'(cOutCount), 128'd9);
    cInValid = 1'b0; cInLast = 1'b0;

    // A: reset after two terms of a frame
    aInValid = 1'b1; aInData = 65'd5; aInLast = 1'b0;
    @(negedge clk);
    aInData = 65'd6;
    @(negedge clk);
    aInValid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready",  128'(aInReady),  128'd0);
    checkOutput("midrst_out_valid", 128'(aOutValid), 128'd0);
    checkOutput("midrst_out_data",  128'(aOutData),  128'd0);
    checkOutput("midrst_out_count", 128'(aOutCount), 128'd0);
    checkOutput("midrst_c_out_ovf", 128'(cOutOvf),   128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_rel_in_ready",  128'(aInReady),  128'd1);
    checkOutput("midrst_rel_out_valid", 128'(aOutValid), 128'd0);
    aInValid = 1'b1; aInData = 65'd5; aInLast = 1'b1;
    @(negedge clk);
    checkOutput("postrst_out_valid", 128'(aOutValid), 128'd1);
    checkOutput("postrst_out_data",  128'(aOutData),  128'd5);
    checkOutput("postrst_out_count", 128'(aOutCount), 128'd1);
    checkOutput("postrst_out_ovf",   128'(aOutOvf),   128'd0);
    aInValid = 1'b0; aInLast = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
